param_waveform_gen: RTL and testbench
=====================================

Name: param_waveform_gen

Overview:
Parametrised, phase-accumulator-based successor to the fixed-rate waveform generator. It produces sawtooth, square, triangle, ROM-sourced sine, full/half-rectified, PWM and midscale outputs. Frequency is programmable and amplitude is scalable, and mode changes are glitch-free because they are applied only at period boundaries. It sits between the control/switch logic and the DAC output register, and drives the address of an external synchronous waveform ROM.

Parameters:
DATA_W, 8, sample width; also ROM address and ROM data width
PHASE_W, 16, phase accumulator width; must be >= DATA_W
MID = 2^(DATA_W-1), derived localparam (not overridable), midscale value

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
en  input  1  accumulator advance enable
wave_sel  input  3  requested mode
freq_word  input  PHASE_W  phase increment per enabled cycle, used as sampled each cycle
amp_shift  input  3  amplitude attenuation by 2^amp_shift about MID
duty  input  DATA_W  PWM threshold
rom_addr  output  DATA_W  ROM address, registered
rom_in  input  DATA_W  ROM data, valid one cycle after rom_addr
data_out  output  DATA_W  registered sample
data_valid  output  1  data_out corresponds to an enabled phase step
sel_active  output  3  mode currently applied
period_tick  output  1  one-cycle pulse on phase wrap

Behaviour:
- Reset (rst=1 at an edge): phase=0, rom_addr=0, data_out=MID, data_valid=0, period_tick=0, sel_active=3'b111, pipeline cleared. Reset mid-operation takes effect at that edge with no drain.
- Phase: when en=1, phase <= phase+freq_word (mod 2^PHASE_W). Wrap = carry out of that add. When en=0, phase holds.
- period_tick=1 in the cycle after a wrapping edge, aligned with the updated phase register.
- p = phase[PHASE_W-1 -: DATA_W].
- rom_addr <= p every cycle.
- Mode switching:
  - wave_sel is continuously latched as pending.
  - sel_active <= pending on a wrapping edge.
  - When en=0, sel_active <= pending at every edge.
  - Otherwise sel_active holds; no mid-period mode change.
- Latency: 2 cycles from the phase register to data_out for every mode. Stage 1 registers p, the mode, amp_shift and duty alongside rom_addr. Stage 2 computes raw from the stage-1 values and rom_in, then registers data_out.
- data_valid = en delayed by 2 cycles.
- raw by mode (stage-1 p):
  - 000 sawtooth: p.
  - 001 square: all-ones if p[MSB]=0, else 0.
  - 010 triangle: p[MSB]=0 -> {p[DATA_W-2:0],1'b0}; else the bitwise inverse of that.
  - 011 sine: rom_in.
  - 100 full-rectified: s = rom_in - MID (signed, DATA_W+1 bits); raw = min(|s|<<1, all-ones).
  - 101 half-rectified: raw = s>0 ? min(s<<1, all-ones) : 0.
  - 110 PWM: all-ones if p < duty, else 0; duty=0 gives constant 0.
  - 111 midscale: MID.
- Scaling: d = raw - MID (signed DATA_W+1 bits); data_out = MID + (d >>> amp_shift). Arithmetic shift, truncating toward -inf. amp_shift=0 passes raw unchanged. The result always lies in range, so no saturation is needed.
- freq_word=0 with en=1: phase constant, no wrap, sel_active frozen until en drops.
- Wrap and wave_sel change on the same edge: the value of wave_sel sampled at that edge is applied.

Test Plan (DATA_W=8, PHASE_W=16):
1. Reset: hold rst 2 cycles with en=1, wave_sel=001 -> data_out=128, data_valid=0, sel_active=7, rom_addr=0, period_tick=0. Assert rst mid-run -> the same values at the next edge.
2. Sawtooth: en=0 with wave_sel=000 (applies immediately), then en=1, freq_word=16'h0100, amp_shift=0 -> data_out = 0,1,2,…,255,0 starting 2 cycles after the phase begins advancing; period_tick every 256 cycles; data_valid rises 2 cycles after en.
3. Square/triangle: freq_word=16'h1000 square -> 8 samples of 255, then 8 of 0. Triangle with amp_shift=1: p=0x20 -> 96; p=0x40 -> 128; p=0x60 -> 160.
4. Glitch-free switch: running 000, change wave_sel to 001 at phase 16'h4000 -> sel_active stays 0 until the wrap edge and becomes 1 in the same cycle period_tick=1. Output stays sawtooth through the wrap and becomes square 2 cycles after.
5. ROM modes: bench ROM returns rom_in = rom_addr one cycle later.
   - Full-rectified: 0x40 -> 128; 0x00 -> 255 (saturated); 0x80 -> 0.
   - Half-rectified: 0xC0 -> 128; 0x40 -> 0.
   - Sine: data_out = rom_in exactly.
6. PWM: duty=0x40, freq_word=16'h0100 -> 64 samples of 255, then 192 of 0, per period. duty=0 -> constant 0. amp_shift=7 -> outputs only 127 or 128.

Source files
------------

// File: rtl/param_waveform_gen_if.sv
// Control, ROM and sample bundle between the control logic, the waveform ROM
// and the generator.
interface param_waveform_gen_if #(
  parameter int DATA_W  = 8,
  parameter int PHASE_W = 16
);
  logic               en;
  logic [2:0]         wave_sel;
  logic [PHASE_W-1:0] freq_word;
  logic [2:0]         amp_shift;
  logic [DATA_W-1:0]  duty;
  logic [DATA_W-1:0]  rom_addr;
  logic [DATA_W-1:0]  rom_in;
  logic [DATA_W-1:0]  data_out;
  logic               data_valid;
  logic [2:0]         sel_active;
  logic               period_tick;

  modport master (
    input  en, wave_sel, freq_word, amp_shift, duty, rom_in,
    output rom_addr, data_out, data_valid, sel_active, period_tick
  );

  modport slave (
    output en, wave_sel, freq_word, amp_shift, duty, rom_in,
    input  rom_addr, data_out, data_valid, sel_active, period_tick
  );
endinterface

// File: rtl/param_waveform_gen.sv
// Phase-accumulator waveform generator: eight output modes, amplitude scaling
// about midscale, and mode changes deferred to period boundaries.
module param_waveform_gen #(
  parameter int DATA_W  = 8,
  parameter int PHASE_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  param_waveform_gen_if.master wg
);

  localparam logic [DATA_W-1:0] MID  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ONES = {DATA_W{1'b1}};

  typedef enum logic [2:0] {
    MODE_SAW      = 3'b000,
    MODE_SQUARE   = 3'b001,
    MODE_TRIANGLE = 3'b010,
    MODE_SINE     = 3'b011,
    MODE_FULLREC  = 3'b100,
    MODE_HALFREC  = 3'b101,
    MODE_PWM      = 3'b110,
    MODE_MID      = 3'b111
  } mode_e;

  function automatic logic [DATA_W-1:0] satOnes(input logic [DATA_W+1:0] v);
    if (|v[DATA_W+1:DATA_W]) return ONES;
    return v[DATA_W-1:0];
  endfunction

  // Doubling restores full swing after the ROM sample is folded about MID.
  function automatic logic [DATA_W-1:0] rectify(input logic [DATA_W-1:0] smp,
                                                input logic halfWave);
    logic signed [DATA_W:0] s;
    logic        [DATA_W:0] mag;
    s   = $signed({1'b0, smp}) - $signed({1'b0, MID});
    mag = s[DATA_W] ? -s : s;
    if (halfWave && (s[DATA_W] || s == '0)) return '0;
    return satOnes({mag, 1'b0});
  endfunction

  function automatic logic [DATA_W-1:0] scaleAmp(input logic [DATA_W-1:0] raw,
                                                 input logic [2:0] sh);
    logic signed [DATA_W:0] d;
    logic signed [DATA_W:0] res;
    d   = $signed({1'b0, raw}) - $signed({1'b0, MID});
    res = (d >>> sh) + $signed({1'b0, MID});
    return res[DATA_W-1:0];
  endfunction

  // Stage 0: phase accumulator and period-boundary mode selection
  logic [PHASE_W:0]   phaseSum;
  logic               wrap;
  logic [PHASE_W-1:0] phase_p0;
  logic               tick_p0;
  mode_e              selActive_p0;
  mode_e              selNext;

  always_comb begin
    phaseSum = {1'b0, phase_p0} + {1'b0, wg.freq_word};
    wrap     = wg.en & phaseSum[PHASE_W];
  end

  always_comb begin
    selNext = selActive_p0;
    if (!wg.en || wrap) selNext = mode_e'(wg.wave_sel);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_p0     <= '0;
      tick_p0      <= 1'b0;
      selActive_p0 <= MODE_MID;
    end else begin
      if (wg.en) phase_p0 <= phaseSum[PHASE_W-1:0];
      tick_p0      <= wrap;
      selActive_p0 <= selNext;
    end
  end

  // Stage 1: sample point, mode and shaping controls travel with rom_addr
  logic [DATA_W-1:0] p_p1;
  logic [DATA_W-1:0] duty_p1;
  logic [2:0]        amp_p1;
  mode_e             mode_p1;
  logic              vld_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_p1    <= '0;
      duty_p1 <= '0;
      amp_p1  <= '0;
      mode_p1 <= MODE_MID;
      vld_p1  <= 1'b0;
    end else begin
      p_p1    <= phase_p0[PHASE_W-1 -: DATA_W];
      duty_p1 <= wg.duty;
      amp_p1  <= wg.amp_shift;
      mode_p1 <= selActive_p0;
      vld_p1  <= wg.en;
    end
  end

  // Stage 2: waveform shaping, amplitude scaling and output register
  logic [DATA_W-1:0] triUp;
  logic [DATA_W-1:0] raw;
  logic [DATA_W-1:0] data_p2;
  logic              vld_p2;

  always_comb begin
    triUp = {p_p1[DATA_W-2:0], 1'b0};
    raw   = MID;
    case (mode_p1)
      MODE_SAW:      raw = p_p1;
      MODE_SQUARE:   raw = p_p1[DATA_W-1] ? '0 : ONES;
      MODE_TRIANGLE: raw = p_p1[DATA_W-1] ? ~triUp : triUp;
      MODE_SINE:     raw = wg.rom_in;
      MODE_FULLREC:  raw = rectify(wg.rom_in, 1'b0);
      MODE_HALFREC:  raw = rectify(wg.rom_in, 1'b1);
      MODE_PWM:      raw = (p_p1 < duty_p1) ? ONES : '0;
      default:       raw = MID;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_p2 <= MID;
      vld_p2  <= 1'b0;
    end else begin
      data_p2 <= scaleAmp(raw, amp_p1);
      vld_p2  <= vld_p1;
    end
  end

  assign wg.rom_addr    = p_p1;
  assign wg.data_out    = data_p2;
  assign wg.data_valid  = vld_p2;
  assign wg.sel_active  = selActive_p0;
  assign wg.period_tick = tick_p0;

endmodule

// File: tb/tb_param_waveform_gen.sv
// Directed bench for param_waveform_gen with a one-cycle-latency ROM that
// echoes its address.
module tb_param_waveform_gen;
  localparam int DW = 8;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  param_waveform_gen_if #(.DATA_W(DW), .PHASE_W(PW)) wg ();

  param_waveform_gen #(.DATA_W(DW), .PHASE_W(PW)) dut (
    .clk(clk),
    .rst(rst),
    .wg (wg)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) wg.rom_in <= wg.rom_addr;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkReset(input string tag);
    chk({tag, "_data"},  int'(wg.data_out),    128);
    chk({tag, "_valid"}, int'(wg.data_valid),  0);
    chk({tag, "_sel"},   int'(wg.sel_active),  7);
    chk({tag, "_addr"},  int'(wg.rom_addr),    0);
    chk({tag, "_tick"},  int'(wg.period_tick), 0);
  endtask

  // Reset, apply mode with en low so it takes effect at once, then enable.
  task automatic startRun(input logic [2:0] mode, input logic [15:0] fw,
                          input logic [2:0] amp, input logic [7:0] dty);
    rst = 1'b1;
    wg.en = 1'b0;
    tick();
    rst = 1'b0;
    wg.wave_sel  = mode;
    wg.freq_word = fw;
    wg.amp_shift = amp;
    wg.duty      = dty;
    repeat (3) tick();
    wg.en = 1'b1;
  endtask

  task automatic stepPhase(input logic [15:0] fw);
    wg.freq_word = fw;
    wg.en = 1'b1;
    tick();
    wg.en = 1'b0;
    wg.freq_word = '0;
  endtask

  task automatic showMode(input logic [2:0] mode, input logic [2:0] amp);
    wg.wave_sel  = mode;
    wg.amp_shift = amp;
    repeat (4) tick();
  endtask

  initial begin
    int triExp [4] = '{64, 96, 128, 160};

    rst          = 1'b1;
    wg.en        = 1'b1;
    wg.wave_sel  = 3'b001;
    wg.freq_word = 16'h0100;
    wg.amp_shift = 3'd0;
    wg.duty      = 8'h00;
    tick();
    tick();
    chkReset("reset");

    // sawtooth, then mid-run reset
    startRun(3'b000, 16'h0100, 3'd0, 8'h00);
    for (int k = 1; k <= 258; k++) begin
      tick();
      if (k == 1) chk("saw_valid_lo", int'(wg.data_valid), 0);
      if (k >= 2) begin
        chk("saw_data", int'(wg.data_out), (k - 2) & 255);
        chk("saw_valid", int'(wg.data_valid), 1);
      end
      if (k == 255 || k == 257) chk("saw_tick_lo", int'(wg.period_tick), 0);
      if (k == 256) chk("saw_tick_hi", int'(wg.period_tick), 1);
    end
    rst = 1'b1;
    tick();
    chkReset("midrst");
    rst = 1'b0;

    // square
    startRun(3'b001, 16'h1000, 3'd0, 8'h00);
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k >= 2) chk("square", int'(wg.data_out), (((k - 2) % 16) < 8) ? 255 : 0);
    end

    // triangle at half amplitude
    startRun(3'b010, 16'h2000, 3'd1, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k >= 2) chk("triangle", int'(wg.data_out), triExp[k-2]);
    end

    // mode change deferred to the wrap; same-edge change on the second wrap
    startRun(3'b000, 16'h0100, 3'd0, 8'h00);
    for (int k = 1; k <= 512; k++) begin
      tick();
      if (k == 64) wg.wave_sel = 3'b001;
      if (k == 255) chk("sw_hold", int'(wg.sel_active), 0);
      if (k == 256) begin
        chk("sw_apply", int'(wg.sel_active), 1);
        chk("sw_tick", int'(wg.period_tick), 1);
      end
      if (k == 257) chk("sw_saw_tail", int'(wg.data_out), 255);
      if (k == 258) chk("sw_sq_head", int'(wg.data_out), 255);
      if (k == 259) chk("sw_sq_next", int'(wg.data_out), 255);
      if (k == 511) begin
        chk("sw2_hold", int'(wg.sel_active), 1);
        wg.wave_sel = 3'b010;
      end
      if (k == 512) begin
        chk("sw2_apply", int'(wg.sel_active), 2);
        chk("sw2_tick", int'(wg.period_tick), 1);
      end
    end

    // zero frequency with en high freezes the mode
    wg.freq_word = 16'h0000;
    wg.wave_sel  = 3'b101;
    repeat (4) tick();
    chk("fz_sel", int'(wg.sel_active), 2);
    chk("fz_tick", int'(wg.period_tick), 0);
    wg.en = 1'b0;
    tick();
    chk("fz_release", int'(wg.sel_active), 5);

    // ROM-sourced modes at held phases
    rst = 1'b1;
    wg.en = 1'b0;
    tick();
    rst = 1'b0;
    stepPhase(16'h4000);
    showMode(3'b100, 3'd0); chk("full_40", int'(wg.data_out), 128);
    showMode(3'b101, 3'd0); chk("half_40", int'(wg.data_out), 0);
    showMode(3'b011, 3'd0); chk("sine_40", int'(wg.data_out), 64);
    stepPhase(16'hC000);
    showMode(3'b100, 3'd0); chk("full_00", int'(wg.data_out), 255);
    stepPhase(16'h8000);
    showMode(3'b100, 3'd0); chk("full_80", int'(wg.data_out), 0);
    stepPhase(16'h4000);
    showMode(3'b101, 3'd0); chk("half_C0", int'(wg.data_out), 128);
    showMode(3'b011, 3'd0); chk("sine_C0", int'(wg.data_out), 192);
    showMode(3'b011, 3'd1); chk("sine_C0_amp1", int'(wg.data_out), 160);

    // PWM
    startRun(3'b110, 16'h0100, 3'd0, 8'h40);
    for (int k = 1; k <= 257; k++) begin
      tick();
      if (k >= 2) chk("pwm", int'(wg.data_out), (((k - 2) & 255) < 64) ? 255 : 0);
    end
    wg.duty = 8'h00;
    repeat (3) tick();
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("pwm_duty0", int'(wg.data_out), 0);
    end

    startRun(3'b110, 16'h0100, 3'd7, 8'h40);
    for (int k = 1; k <= 130; k++) begin
      tick();
      if (k >= 2) chk("pwm_amp7", int'(wg.data_out), (((k - 2) & 255) < 64) ? 128 : 127);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
